alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Iterative 32-bit multiply/divide unit that sits directly upstream of the ALU's 8:1 result multiplexer and drives one of its data inputs. It accepts two operands and an op code through a start/busy/done handshake, computes over a fixed number of cycles with a shift-add multiplier or a restoring divider, then holds the selected 32-bit result stable for the mux until the next operation completes.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when accepting (IDLE or DONE)
- op  input  2  00 MUL low word, 01 MUL high word, 10 DIV quotient, 11 DIV remainder
- sgn  input  1  signed operands (honoured only with MULDIV_SIGNED_EN)
- a  input  WIDTH  multiplicand / dividend, latched at accept
- b  input  WIDTH  multiplier / divisor, latched at accept
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when result updates
- result  output  WIDTH  held result; feeds a mux data input
- div_zero  output  1  last completed op was DIV/REM with b == 0; held with result

## Operation
- Reset (async, rst_n low): state IDLE; busy=0, done=0, result=0, div_zero=0, counter=0. Reset mid-RUN aborts; no done pulse.
- FSM: IDLE -> RUN on start; RUN -> DONE after WIDTH iterations; DONE -> RUN if start, else IDLE.
- Accept: start high in IDLE or DONE latches a, b, op, sgn. start during RUN ignored (not queued).
- MUL: 2·WIDTH product register; each RUN cycle adds shifted multiplicand if current multiplier LSB is 1, shifts right. op 00 returns bits [WIDTH-1:0], op 01 bits [2·WIDTH-1:WIDTH].
- DIV: restoring; each RUN cycle shift remainder left by one, bring in next dividend bit MSB-first, subtract divisor if no borrow, set quotient bit.
- Divide by zero: full latency preserved; quotient = all ones, remainder = a; div_zero=1. div_zero is 0 for MUL ops.
- result and div_zero change only on the DONE entry cycle; held otherwise, including through IDLE and the next RUN.

## Timing
- start accepted at edge T -> busy high from T+1 through T+WIDTH; done=1 and new result visible in cycle T+WIDTH+1 (latency WIDTH+1 cycles).
- Back-to-back: start high during done cycle is accepted; busy rises next cycle, no idle bubble.
- done is exactly one cycle wide; busy and done never high together.
- result is registered; no combinational path from a/b/op to result.

## Configuration
- MULDIV_SIGNED_EN defined: sgn=1 selects two's-complement. Operands converted to magnitude at accept; sign fixed at DONE (product sign a^b; quotient sign a^b; remainder sign of a). Overflow -2^(WIDTH-1) / -1: quotient = 0x80000000, remainder = 0, div_zero=0. Divide by zero: quotient all ones, remainder = a (signed).
- Undefined: sgn ignored, all ops unsigned; no sign logic synthesised. Port list identical in both builds.

## Structure
- Package alu_muldiv_pkg: op encodings (OP_MUL, OP_MULH, OP_DIV, OP_REM), FSM state encodings (IDLE, RUN, DONE), default WIDTH.
- One combinational sub-module, muldiv_step: single shift-add / restoring-subtract iteration, instantiated once in the top datapath; counter and FSM in the top.

## Test plan
- Reset during RUN (after 5 cycles of MUL 7×9) -> busy=0, done=0, result=0 immediately; no done pulse after rst_n release.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF, op 00 then op 01 -> results 0x00000001 and 0xFFFFFFFE; done exactly 33 cycles after each accept.
- DIV a=100, b=7: op 10 -> 14, op 11 -> 2; div_zero=0.
- DIV a=0x1234, b=0: op 10 -> 0xFFFFFFFF with div_zero=1; op 11 -> 0x00001234; full 33-cycle latency.
- Back-to-back: start held through done cycle with new operands (6×7) -> second result 42 with no idle cycle; start pulsed mid-RUN ignored.
- MULDIV_SIGNED_EN, sgn=1: -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; same stimulus without the macro -> unsigned results.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// alu_muldiv_pkg: op and FSM encodings plus default width for the iterative mul/div unit
package alu_muldiv_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULH = 2'b01, OP_DIV = 2'b10, OP_REM = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: start/busy/done request bus between the issuing stage and the mul/div unit
interface alu_muldiv_seq_if
  import alu_muldiv_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic             start;
  logic [1:0]       op;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_zero;
  modport master(output start, op, sgn, a, b, input busy, done, result, div_zero);
  modport slave(input start, op, sgn, a, b, output busy, done, result, div_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on the shared accumulator
module muldiv_step
  import alu_muldiv_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  always_comb begin
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge = sh >= {1'b0, opnd};
    // the true difference is below opnd, so the low WIDTH bits are exact
    diff = sh[WIDTH-1:0] - opnd;
    acc_next = is_div ? {(ge ? diff : sh[WIDTH-1:0]), acc[WIDTH-2:0], ge}
                      : {sum, acc[WIDTH-1:1]};
  end
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative mul/div feeding the ALU result mux; MULDIV_SIGNED_EN enables signed ops
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input logic             clk,
  input logic             rst_n,
  alu_muldiv_seq_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               dzo_q, dzo_d, busy_q, busy_d, done_q, done_d;
  logic               a_neg, b_neg, accept, last;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_SIGNED_EN
  assign a_neg = io.sgn & io.a[WIDTH-1];
  assign b_neg = io.sgn & io.b[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif
  assign a_mag = a_neg ? -io.a : io.a;
  assign b_mag = b_neg ? -io.b : io.b;
  assign accept = io.start & (state_q != RUN);
  assign last = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_q[1]),
    .acc     (acc_q),
    .opnd    (opnd_q),
    .acc_next(acc_step)
  );
  // magnitudes are iterated; signs are restored only when the result is captured
  assign prod = neg_q ? -acc_step : acc_step;
  assign quo = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
  assign rem = rneg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    opnd_d = opnd_q;
    acc_d = acc_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    dz_d = dz_q;
    res_d = res_q;
    dzo_d = dzo_q;
    if (accept) begin
      state_d = RUN;
      cnt_d = '0;
      op_d = io.op;
      opnd_d = io.op[1] ? b_mag : a_mag;
      acc_d = {{WIDTH{1'b0}}, io.op[1] ? a_mag : b_mag};
      neg_d = a_neg ^ b_neg;
      rneg_d = a_neg;
      dz_d = io.op[1] & (io.b == '0);
    end else if (state_q == RUN) begin
      acc_d = acc_step;
      cnt_d = cnt_q + CW'(1);
      state_d = last ? DONE : RUN;
      res_d = !last ? res_q :
              op_q[1] ? (op_q[0] ? rem : (dz_q ? '1 : quo))
                      : (op_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);
      dzo_d = last ? dz_q : dzo_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    busy_d = state_d == RUN;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= '0;
      opnd_q <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q <= 1'b0;
      res_q <= '0;
      dzo_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      opnd_q <= opnd_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      dz_q <= dz_d;
      res_q <= res_d;
      dzo_q <= dzo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign io.busy = busy_q;
  assign io.done = done_q;
  assign io.result = res_q;
  assign io.div_zero = dzo_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed self-checking bench for alu_muldiv_seq (both MULDIV_SIGNED_EN builds)
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  alu_muldiv_seq_if bus();
  alu_muldiv_seq dut (.clk(clk), .rst_n(rst_n), .io(bus.slave));
  always #5 clk = ~clk;
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic sgn, output int cyc, output logic ov);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.sgn = sgn;
    cyc = 0;
    ov = 1'b0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
      if (bus.busy && bus.done) ov = 1'b1;
    end while (!bus.done && cyc < 100);
  endtask
  task automatic test_reset;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %0b want 0", bus.div_zero); end
  endtask
  task automatic test_mul;
    int cyc; logic ov;
    run_op(32'd7, 32'd9, 2'b00, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'd63) begin errors++; $display("FAIL mul_7x9 got %h want 3f", bus.result); end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'h00000001) begin errors++; $display("FAIL mul_lo got %h want 00000001", bus.result); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_lo_latency got %0d want 33", cyc); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mul_busy_done_overlap got %0b want 0", ov); end
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_hi got %h want fffffffe", bus.result); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mul_hi_latency got %0d want 33", cyc); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got %0b want 0", bus.done); end
    checks++; if (bus.result !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_hold got %h want fffffffe", bus.result); end
  endtask
  task automatic test_div;
    int cyc; logic ov;
    run_op(32'd100, 32'd7, 2'b10, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'd14) begin errors++; $display("FAIL div_q got %h want 0000000e", bus.result); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL div_q_dz got %0b want 0", bus.div_zero); end
    run_op(32'd100, 32'd7, 2'b11, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'd2) begin errors++; $display("FAIL div_r got %h want 00000002", bus.result); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_latency got %0d want 33", cyc); end
  endtask
  task automatic test_div_zero;
    int cyc; logic ov;
    run_op(32'h1234, 32'h0, 2'b10, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_q got %h want ffffffff", bus.result); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", bus.div_zero); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", cyc); end
    run_op(32'h1234, 32'h0, 2'b11, 1'b0, cyc, ov);
    checks++; if (bus.result !== 32'h00001234) begin errors++; $display("FAIL dz_r got %h want 00001234", bus.result); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_r_flag got %0b want 1", bus.div_zero); end
    repeat (3) @(negedge clk);
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got %0b want 1", bus.div_zero); end
    run_op(32'd2, 32'd3, 2'b00, 1'b0, cyc, ov);
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_mul got %0b want 0", bus.div_zero); end
    checks++; if (bus.result !== 32'd6) begin errors++; $display("FAIL mul_2x3 got %h want 6", bus.result); end
  endtask
  task automatic test_reset_mid_run;
    int dones = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd9; bus.op = 2'b00; bus.sgn = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_run_busy got %0b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_run_done got %0b want 0", bus.done); end
    checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rst_run_result got %h want 0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL rst_run_no_done got %0d want 0", dones); end
  endtask
  task automatic test_back_to_back;
    int cyc = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd3; bus.b = 32'd5; bus.op = 2'b00; bus.sgn = 1'b0;
    @(negedge clk);
    bus.a = 32'd6; bus.b = 32'd7;
    cyc = 1;
    while (!bus.done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (bus.result !== 32'd15) begin errors++; $display("FAIL b2b_first got %h want f", bus.result); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d want 33", cyc); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_no_bubble got %0b want 1", bus.busy); end
    bus.start = 1'b0;
    cyc = 1;
    repeat (9) begin @(negedge clk); cyc++; end
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd100;
    @(negedge clk); cyc++;
    bus.start = 1'b0;
    while (!bus.done && cyc < 100) begin @(negedge clk); cyc++; end
    checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL b2b_second got %h want 2a", bus.result); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d want 33", cyc); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_ignored got %0b want 0", bus.busy); end
  endtask
  task automatic test_signed;
    int cyc; logic ov;
`ifdef MULDIV_SIGNED_EN
    logic [31:0] q1 = 32'hFFFFFFFD, r1 = 32'hFFFFFFFF, q2 = 32'h80000000, r2 = 32'h0, mh = 32'hFFFFFFFF;
`else
    logic [31:0] q1 = 32'h7FFFFFFC, r1 = 32'h1, q2 = 32'h0, r2 = 32'h80000000, mh = 32'h4;
`endif
    run_op(32'hFFFFFFF9, 32'd2, 2'b10, 1'b1, cyc, ov);
    checks++; if (bus.result !== q1) begin errors++; $display("FAIL sgn_div_q got %h want %h", bus.result, q1); end
    run_op(32'hFFFFFFF9, 32'd2, 2'b11, 1'b1, cyc, ov);
    checks++; if (bus.result !== r1) begin errors++; $display("FAIL sgn_div_r got %h want %h", bus.result, r1); end
    run_op(32'h80000000, 32'hFFFFFFFF, 2'b10, 1'b1, cyc, ov);
    checks++; if (bus.result !== q2) begin errors++; $display("FAIL sgn_ovf_q got %h want %h", bus.result, q2); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL sgn_ovf_dz got %0b want 0", bus.div_zero); end
    run_op(32'h80000000, 32'hFFFFFFFF, 2'b11, 1'b1, cyc, ov);
    checks++; if (bus.result !== r2) begin errors++; $display("FAIL sgn_ovf_r got %h want %h", bus.result, r2); end
    run_op(32'hFFFFFFFD, 32'd5, 2'b00, 1'b1, cyc, ov);
    checks++; if (bus.result !== 32'hFFFFFFF1) begin errors++; $display("FAIL sgn_mul_lo got %h want fffffff1", bus.result); end
    run_op(32'hFFFFFFFD, 32'd5, 2'b01, 1'b1, cyc, ov);
    checks++; if (bus.result !== mh) begin errors++; $display("FAIL sgn_mul_hi got %h want %h", bus.result, mh); end
  endtask
  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_mul;
    test_div;
    test_div_zero;
    test_reset_mid_run;
    test_back_to_back;
    test_signed;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
